// File: rtl/ram_arb.sv
// rtl/ram_arb.sv - two-requester PSRAM arbiter and single-word transaction sequencer
// CPU port has priority; a starve counter guarantees the host a slot under sustained CPU load.
module ram_arb #(
  parameter int AW           = 22,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic          cpu_byte,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,

  input  logic          host_req,
  input  logic          host_we,
  input  logic          host_byte,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic [DW-1:0] host_rdata,
  output logic          host_ack,

  input  logic          ram_init,
  input  logic          ram_busy,
  input  logic          ram_done,
  input  logic [DW-1:0] ram_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_read,
  output logic          ram_write,
  output logic          ram_byte,

  output logic          grant_host,
  output logic          busy,
  output logic          tmo
);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_ACK   = 3'd4
  } state_t;

  localparam logic [3:0] LP_STARVE = 4'(STARVE_LIMIT);
  localparam logic [7:0] LP_TMO    = 8'(TIMEOUT);

  state_t        r_state;
  state_t        w_next;

  logic [3:0]    r_starve;
  logic [7:0]    r_tmo_cnt;
  logic          r_tmo;
  logic          r_we;
  logic          r_byte;
  logic          r_grant_host;
  logic          r_busy;
  logic [AW-1:0] r_ram_addr;
  logic [DW-1:0] r_ram_wdata;
  logic [DW-1:0] r_cpu_rdata;
  logic [DW-1:0] r_host_rdata;

  logic          w_pick_host;
  logic          w_grant;
  logic          w_done_ok;
  logic          w_expire;
  logic          w_load_rdata;
  logic [DW-1:0] w_rdata_val;

  always_comb begin
    w_pick_host  = host_req & (~cpu_req | (r_starve == LP_STARVE));
    w_grant      = (r_state == S_IDLE) & ~ram_busy & (cpu_req | host_req);
    w_done_ok    = (r_state == S_WAIT) & ram_done;
    w_expire     = (r_state == S_WAIT) & ~ram_done & (r_tmo_cnt == LP_TMO);
    w_load_rdata = (w_done_ok | w_expire) & ~r_we;
    w_rdata_val  = w_done_ok ? ram_rdata : {DW{1'b1}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT:  if (ram_init) w_next = S_IDLE;
      S_IDLE:  if (w_grant) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (w_done_ok || w_expire) w_next = S_ACK;
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve     <= '0;
      r_tmo_cnt    <= '0;
      r_tmo        <= 1'b0;
      r_we         <= 1'b0;
      r_byte       <= 1'b0;
      r_grant_host <= 1'b0;
      r_busy       <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
      r_cpu_rdata  <= '0;
      r_host_rdata <= '0;
    end else begin
      // Registered so that it reads 0 in the cycle right after reset.
      r_busy <= (w_next != S_IDLE);

      if (w_grant) begin
        r_grant_host <= w_pick_host;
        r_ram_addr   <= w_pick_host ? host_addr  : cpu_addr;
        r_ram_wdata  <= w_pick_host ? host_wdata : cpu_wdata;
        r_we         <= w_pick_host ? host_we    : cpu_we;
        r_byte       <= w_pick_host ? (host_we & host_byte) : (cpu_we & cpu_byte);
      end

      if (w_grant && w_pick_host) begin
        r_starve <= '0;
      end else if (w_grant && host_req) begin
        if (r_starve != LP_STARVE) r_starve <= r_starve + 4'd1;
      end else if ((r_state == S_IDLE) && !host_req) begin
        r_starve <= '0;
      end

      if (r_state == S_ISSUE) begin
        r_tmo_cnt <= '0;
      end else if ((r_state == S_WAIT) && !ram_done && !w_expire) begin
        r_tmo_cnt <= r_tmo_cnt + 8'd1;
      end

      if (w_expire) r_tmo <= 1'b1;

      // An abandoned read returns all-ones so the master never sees stale data.
      if (w_load_rdata) begin
        if (r_grant_host) r_host_rdata <= w_rdata_val;
        else              r_cpu_rdata  <= w_rdata_val;
      end
    end
  end

  assign ram_addr   = r_ram_addr;
  assign ram_wdata  = r_ram_wdata;
  assign ram_byte   = r_byte;
  assign ram_read   = (r_state == S_ISSUE) & ~r_we;
  assign ram_write  = (r_state == S_ISSUE) &  r_we;
  assign cpu_ack    = (r_state == S_ACK) & ~r_grant_host;
  assign host_ack   = (r_state == S_ACK) &  r_grant_host;
  assign cpu_rdata  = r_cpu_rdata;
  assign host_rdata = r_host_rdata;
  assign grant_host = r_grant_host;
  assign busy       = r_busy;
  assign tmo        = r_tmo;

endmodule

// File: tb/tb_ram_arb.sv
// tb/tb_ram_arb.sv - scoreboard testbench for ram_arb
// Stimulus pushes expected commands/acks; the RAM model and ack monitor pop and compare.
`timescale 1ns/1ps
module tb_ram_arb;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_byte;
  logic [21:0] cpu_addr;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic        cpu_ack;
  logic        host_req, host_we, host_byte;
  logic [21:0] host_addr;
  logic [15:0] host_wdata, host_rdata;
  logic        host_ack;
  logic        ram_init, ram_busy, ram_done;
  logic [15:0] ram_rdata;
  logic [21:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_read, ram_write, ram_byte;
  logic        grant_host, busy, tmo;

  ram_arb #(.AW(22), .DW(16), .STARVE_LIMIT(4), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_byte(cpu_byte), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .host_req(host_req), .host_we(host_we), .host_byte(host_byte), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack),
    .ram_init(ram_init), .ram_busy(ram_busy), .ram_done(ram_done), .ram_rdata(ram_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_read(ram_read), .ram_write(ram_write),
    .ram_byte(ram_byte), .grant_host(grant_host), .busy(busy), .tmo(tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        host;
    logic        we;
    logic        byt;
    logic [21:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          dly;
  } cmd_t;

  typedef struct {
    logic        host;
    logic [15:0] cpu_rd;
    logic [15:0] host_rd;
  } ack_t;

  cmd_t        cmd_q[$];
  ack_t        ack_q[$];
  int          n_checks = 0;
  int          n_err    = 0;
  int          strobe_cnt = 0;
  int          ack_cnt    = 0;
  logic [15:0] exp_cpu_rd  = 16'h0;
  logic [15:0] exp_host_rd = 16'h0;
  ack_t        mon_a;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input int act, input int exp);
    n_checks++;
    n_err++;
    $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // RAM controller model: checks each command strobe, then answers after the queued delay.
  initial begin : ram_model
    int          cnt;
    logic [15:0] dat;
    cmd_t        c;
    cnt = -1;
    dat = 16'h0;
    ram_done  = 1'b0;
    ram_rdata = 16'hDEAD;
    forever begin
      @(posedge clk); #1;
      ram_done  = 1'b0;
      ram_rdata = 16'hDEAD;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          ram_done  = 1'b1;
          ram_rdata = dat;
          cnt = -1;
        end
      end
      if (ram_read || ram_write) begin
        strobe_cnt++;
        if (cmd_q.size() == 0) begin
          flag("unexpected_strobe", strobe_cnt, 0);
        end else begin
          c = cmd_q.pop_front();
          chk("cmd_write", ram_write, c.we);
          chk("cmd_read", ram_read, !c.we);
          chk("cmd_addr", ram_addr, c.addr);
          chk("cmd_byte", ram_byte, c.byt & c.we);
          chk("cmd_owner", grant_host, c.host);
          if (c.we) chk("cmd_wdata", ram_wdata, c.wdata);
          cnt = c.dly;
          dat = c.rdata;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cpu_ack || host_ack) begin
      ack_cnt++;
      if (ack_q.size() == 0) begin
        flag("unexpected_ack", ack_cnt, 0);
      end else begin
        mon_a = ack_q.pop_front();
        chk("ack_cpu", cpu_ack, !mon_a.host);
        chk("ack_host", host_ack, mon_a.host);
        chk("ack_grant_host", grant_host, mon_a.host);
        chk("cpu_rdata", cpu_rdata, mon_a.cpu_rd);
        chk("host_rdata", host_rdata, mon_a.host_rd);
      end
    end
  end

  task automatic expect_xact(input logic host, input logic we, input logic byt,
                             input logic [21:0] addr, input logic [15:0] wd,
                             input logic [15:0] rd, input int dly, input logic do_ack);
    cmd_t c;
    ack_t a;
    c.host = host; c.we = we; c.byt = byt; c.addr = addr;
    c.wdata = wd; c.rdata = rd; c.dly = dly;
    cmd_q.push_back(c);
    if (do_ack) begin
      if (!we) begin
        if (host) exp_host_rd = (dly < 0) ? 16'hFFFF : rd;
        else      exp_cpu_rd  = (dly < 0) ? 16'hFFFF : rd;
      end
      a.host = host; a.cpu_rd = exp_cpu_rd; a.host_rd = exp_host_rd;
      ack_q.push_back(a);
    end
  endtask

  task automatic drive(input logic host, input logic we, input logic byt,
                       input logic [21:0] addr, input logic [15:0] wd);
    if (host) begin
      host_req = 1'b1; host_we = we; host_byte = byt; host_addr = addr; host_wdata = wd;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_byte = byt; cpu_addr = addr; cpu_wdata = wd;
    end
  endtask

  task automatic wait_ack(input logic host, output int cyc);
    logic got;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      got = host ? host_ack : cpu_ack;
    end
    chk(host ? "host_ack_seen" : "cpu_ack_seen", got, 1'b1);
    @(posedge clk); #1;
    if (host) host_req = 1'b0;
    else      cpu_req  = 1'b0;
  endtask

  task automatic xact(input logic host, input logic we, input logic byt,
                      input logic [21:0] addr, input logic [15:0] wd,
                      input logic [15:0] rd, input int dly, output int lat);
    expect_xact(host, we, byt, addr, wd, rd, dly, 1'b1);
    drive(host, we, byt, addr, wd);
    wait_ack(host, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int lat;
    int s0;
    int a0;
    int cpu_n;
    logic drop_h, drop_c;

    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_byte = 0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 0; host_we = 0; host_byte = 0; host_addr = '0; host_wdata = '0;
    ram_init = 0; ram_busy = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_outputs", {ram_read, ram_write, ram_byte, ram_addr, ram_wdata, cpu_ack, host_ack,
                        cpu_rdata, host_rdata, grant_host, busy, tmo}, 128'h0);

    // Requests are ignored until calibration completes
    expect_xact(1'b0, 1'b0, 1'b0, 22'o00000100, 16'h0, 16'h1234, 1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 22'o00000100, 16'h0);
    s0 = strobe_cnt;
    repeat (20) @(posedge clk);
    #1;
    chk("init_no_strobe", strobe_cnt, s0);
    chk("init_busy", busy, 1'b1);
    ram_init = 1'b1;
    wait_ack(1'b0, lat);
    chk("init_latency", lat, 4);

    xact(1'b0, 1'b0, 1'b0, 22'o00001000, 16'h0, 16'o123456, 5, lat);
    chk("cpu_read_latency", lat, 7);
    xact(1'b1, 1'b0, 1'b0, 22'o00000200, 16'h0, 16'hBEEF, 2, lat);
    chk("host_read_latency", lat, 4);
    xact(1'b1, 1'b1, 1'b1, 22'o17757777, 16'h00A5, 16'h0, 3, lat);
    chk("host_bytewr_latency", lat, 5);
    xact(1'b0, 1'b0, 1'b1, 22'o00000001, 16'h0, 16'h5A5A, 1, lat);
    chk("cpu_byterd_latency", lat, 3);
    xact(1'b0, 1'b1, 1'b0, 22'o00007776, 16'hC0DE, 16'h0, 1, lat);
    chk("cpu_write_latency", lat, 3);

    // Controller busy holds the IDLE decision
    ram_busy = 1'b1;
    expect_xact(1'b0, 1'b0, 1'b0, 22'o00000040, 16'h0, 16'h0F0F, 2, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 22'o00000040, 16'h0);
    s0 = strobe_cnt;
    repeat (6) @(posedge clk);
    #1;
    chk("stall_no_strobe", strobe_cnt, s0);
    chk("stall_idle", busy, 1'b0);
    ram_busy = 1'b0;
    wait_ack(1'b0, lat);
    chk("stall_latency", lat, 4);

    // Starvation: C C C C H C with both requests held
    for (int i = 0; i < 4; i++)
      expect_xact(1'b0, 1'b0, 1'b0, 22'o00002000, 16'h0, 16'h1000 + 16'(i), 1, 1'b1);
    expect_xact(1'b1, 1'b0, 1'b0, 22'o00003000, 16'h0, 16'h2222, 1, 1'b1);
    expect_xact(1'b0, 1'b0, 1'b0, 22'o00002000, 16'h0, 16'h1004, 1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 22'o00002000, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 22'o00003000, 16'h0);
    cpu_n = 0; drop_h = 0; drop_c = 0;
    for (int t = 0; t < 200 && (cpu_req || host_req); t++) begin
      @(posedge clk); #1;
      if (drop_h) begin host_req = 1'b0; drop_h = 1'b0; end
      if (drop_c) begin cpu_req = 1'b0; drop_c = 1'b0; end
      if (host_ack) drop_h = 1'b1;
      if (cpu_ack) begin
        cpu_n++;
        if (cpu_n == 5) drop_c = 1'b1;
      end
    end
    chk("starve_cpu_acks", cpu_n, 5);
    chk("starve_reqs_dropped", {cpu_req, host_req}, 2'b00);

    // Timeout: the read is never answered
    chk("tmo_before", tmo, 1'b0);
    xact(1'b0, 1'b0, 1'b0, 22'o00000777, 16'h0, 16'h0, -1, lat);
    chk("tmo_latency", lat, 258);
    chk("tmo_set", tmo, 1'b1);
    xact(1'b1, 1'b0, 1'b0, 22'o00000300, 16'h0, 16'h3141, 2, lat);
    chk("tmo_sticky", tmo, 1'b1);

    // Reset during WAIT drops the transaction
    expect_xact(1'b0, 1'b0, 1'b0, 22'o00000500, 16'h0, 16'h7777, 6, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 22'o00000500, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    a0 = ack_cnt;
    rst = 1'b1; ram_init = 1'b0; cpu_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_mid_outputs", {ram_read, ram_write, ram_byte, ram_addr, ram_wdata, cpu_ack, host_ack,
                            cpu_rdata, host_rdata, grant_host, busy, tmo}, 128'h0);
    s0 = strobe_cnt;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_mid_no_ack", ack_cnt, a0);
    chk("rst_mid_no_strobe", strobe_cnt, s0);
    chk("rst_mid_in_init", busy, 1'b1);
    exp_cpu_rd  = 16'h0;
    exp_host_rd = 16'h0;
    ram_init = 1'b1;
    xact(1'b0, 1'b0, 1'b0, 22'o00000600, 16'h0, 16'h2468, 1, lat);
    chk("recover_latency", lat, 4);
    chk("recover_tmo_clear", tmo, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("cmd_q_empty", cmd_q.size(), 0);
    chk("ack_q_empty", ack_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
